// File: rtl/memory_responder_if.sv
// CPU fetch/load/store port and program-loader port of the memory responder.
// master = CPU + loader side, slave = responder side.
interface memory_responder_if;
    logic [7:0] SaidaPCLeEndereco;
    logic [7:0] Instrucao;
    logic [7:0] EnderecoDado;
    logic [7:0] DadoEscrito;
    logic       EscMem;
    logic       LerMem;
    logic [7:0] LeDado;
    logic       CarregaValido;
    logic [7:0] CarregaDado;
    logic       CarregaFim;
    logic       CarregaPronto;
    logic       CpuReset;

    modport master (
        output SaidaPCLeEndereco, EnderecoDado, DadoEscrito, EscMem, LerMem,
               CarregaValido, CarregaDado, CarregaFim,
        input  Instrucao, LeDado, CarregaPronto, CpuReset
    );

    modport slave (
        input  SaidaPCLeEndereco, EnderecoDado, DadoEscrito, EscMem, LerMem,
               CarregaValido, CarregaDado, CarregaFim,
        output Instrucao, LeDado, CarregaPronto, CpuReset
    );
endinterface

// File: rtl/memory_responder.sv
// Memory responder for a single-cycle CPU: a byte-wide loader fills the
// instruction memory while the CPU is held in reset, then the CPU runs with
// zero-latency instruction fetch and data load from separate arrays.
module memory_responder #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                  Clock,
    input  logic                  reset,
    memory_responder_if.slave     bus
);

    typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;

    // Memories are not touched by reset; power-up content is zero.
    logic [7:0] imem_q [IMEM_DEPTH] = '{default: 8'h00};
    logic [7:0] dmem_q [DMEM_DEPTH] = '{default: 8'h00};

    logic load_wr, store_wr;

    // Write enables; reset blocks every memory write in its cycle.
    assign load_wr  = !reset && (state_q == S_LOAD) && bus.CarregaValido;
    assign store_wr = !reset && (state_q == S_RUN)  && bus.EscMem;

    // State register and load pointer.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= S_LOAD;
            ptr_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: leave LOAD on end-of-program or after filling byte 255;
    // RUN is only left through reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == S_LOAD) begin
            if (bus.CarregaValido)
                ptr_d = ptr_q + 8'h01;
            if (bus.CarregaFim || (bus.CarregaValido && ptr_q == 8'hFF))
                state_d = S_RUN;
        end
    end

    // Outputs: loader handshake and CPU reset in LOAD, memory reads in RUN.
    always_comb begin
        bus.CarregaPronto = (state_q == S_LOAD);
        bus.CpuReset      = (state_q == S_LOAD);
        bus.Instrucao     = 8'h00;
        bus.LeDado        = 8'h00;
        if (state_q == S_RUN) begin
            bus.Instrucao = imem_q[bus.SaidaPCLeEndereco];
            if (bus.LerMem)
                bus.LeDado = dmem_q[bus.EnderecoDado];
        end
    end

    // Instruction memory: written only by the loader.
    always_ff @(posedge Clock) begin
        if (load_wr)
            imem_q[ptr_q] <= bus.CarregaDado;
    end

    // Data memory: written only by CPU stores; reads see the old value
    // until the edge.
    always_ff @(posedge Clock) begin
        if (store_wr)
            dmem_q[bus.EnderecoDado] <= bus.DadoEscrito;
    end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a vector table plus hand-written
// sequences for reload-after-reset and the 256-byte stream.
module tb_memory_responder;

    logic Clock;
    logic reset;
    memory_responder_if bus();

    memory_responder #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       rst;
        logic [7:0] pc, addr, wd;
        logic       esc, ler, cv;
        logic [7:0] cd;
        logic       cf;
        logic [7:0] e_ins, e_ld;
        logic       e_rdy, e_crst;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic rst, logic [7:0] pc, logic [7:0] addr,
                                logic [7:0] wd, logic esc, logic ler, logic cv,
                                logic [7:0] cd, logic cf, logic [7:0] e_ins,
                                logic [7:0] e_ld, logic e_rdy, logic e_crst);
        vec_t v;
        v.rst = rst; v.pc = pc; v.addr = addr; v.wd = wd;
        v.esc = esc; v.ler = ler; v.cv = cv; v.cd = cd; v.cf = cf;
        v.e_ins = e_ins; v.e_ld = e_ld; v.e_rdy = e_rdy; v.e_crst = e_crst;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then take the edge.
    task automatic apply(input string tag, input vec_t v);
        reset                 = v.rst;
        bus.SaidaPCLeEndereco = v.pc;
        bus.EnderecoDado      = v.addr;
        bus.DadoEscrito       = v.wd;
        bus.EscMem            = v.esc;
        bus.LerMem            = v.ler;
        bus.CarregaValido     = v.cv;
        bus.CarregaDado       = v.cd;
        bus.CarregaFim        = v.cf;
        #2;
        chk({tag, " Instrucao"},     bus.Instrucao,            v.e_ins);
        chk({tag, " LeDado"},        bus.LeDado,               v.e_ld);
        chk({tag, " CarregaPronto"}, {7'd0, bus.CarregaPronto}, {7'd0, v.e_rdy});
        chk({tag, " CpuReset"},      {7'd0, bus.CpuReset},      {7'd0, v.e_crst});
        @(posedge Clock);
        #1;
    endtask

    vec_t tbl [17];

    initial begin
        //               rst pc    addr  wd    esc ler cv cd    cf  ins   ld    rdy crst
        tbl[0]  = mk(1, 8'h00, 8'h00, 8'h00, 1, 0, 1, 8'hEE, 1, 8'h00, 8'h00, 1, 1); // reset wins
        tbl[1]  = mk(0, 8'h00, 8'h10, 8'h99, 1, 1, 1, 8'h11, 0, 8'h00, 8'h00, 1, 1); // store ignored in LOAD
        tbl[2]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h22, 0, 8'h00, 8'h00, 1, 1);
        tbl[3]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h33, 0, 8'h00, 8'h00, 1, 1);
        tbl[4]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 1); // end pulse
        tbl[5]  = mk(0, 8'h01, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0);
        tbl[6]  = mk(0, 8'h02, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h33, 8'h00, 0, 0);
        tbl[7]  = mk(0, 8'h03, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0); // unloaded = 0
        tbl[8]  = mk(0, 8'h00, 8'h40, 8'hA5, 1, 0, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0); // store
        tbl[9]  = mk(0, 8'h00, 8'h40, 8'h00, 0, 1, 0, 8'h00, 0, 8'h11, 8'hA5, 0, 0); // load
        tbl[10] = mk(0, 8'h00, 8'h40, 8'h00, 0, 0, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0); // LerMem=0
        tbl[11] = mk(0, 8'h00, 8'h10, 8'h7E, 1, 1, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0); // old value
        tbl[12] = mk(0, 8'h00, 8'h10, 8'h00, 0, 1, 0, 8'h00, 0, 8'h11, 8'h7E, 0, 0); // new value
        tbl[13] = mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hFF, 1, 8'h11, 8'h00, 0, 0); // loader in RUN
        tbl[14] = mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0); // imem unchanged
        tbl[15] = mk(1, 8'h00, 8'h20, 8'h55, 1, 1, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0); // reset blocks store
        tbl[16] = mk(0, 8'h00, 8'h20, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 1); // back in LOAD

        reset = 1'b1;
        bus.SaidaPCLeEndereco = '0; bus.EnderecoDado = '0; bus.DadoEscrito = '0;
        bus.EscMem = 1'b0; bus.LerMem = 1'b0;
        bus.CarregaValido = 1'b0; bus.CarregaDado = '0; bus.CarregaFim = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        for (int i = 0; i < 17; i++)
            apply($sformatf("row%0d", i), tbl[i]);

        // Partial load of five bytes, reset, then reload two bytes.
        for (int i = 0; i < 5; i++)
            apply($sformatf("ld1_%0d", i),
                  mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hA1 + 8'(i), 0, 8'h00, 8'h00, 1, 1));
        apply("rst_mid", mk(1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hEE, 0, 8'h00, 8'h00, 1, 1));
        apply("ld2_0",   mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hC1, 0, 8'h00, 8'h00, 1, 1));
        apply("ld2_1",   mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hC2, 1, 8'h00, 8'h00, 1, 1)); // byte + end
        apply("re_pc0",  mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'hC1, 8'h00, 0, 0));
        apply("re_pc1",  mk(0, 8'h01, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'hC2, 8'h00, 0, 0));
        apply("re_pc2",  mk(0, 8'h02, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'hA3, 8'h00, 0, 0));
        apply("re_pc3",  mk(0, 8'h03, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'hA4, 8'h00, 0, 0));
        apply("re_pc4",  mk(0, 8'h04, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'hA5, 8'h00, 0, 0));
        apply("dm_20",   mk(0, 8'h00, 8'h20, 8'h00, 0, 1, 0, 8'h00, 0, 8'hC1, 8'h00, 0, 0));
        apply("dm_40",   mk(0, 8'h00, 8'h40, 8'h00, 0, 1, 0, 8'h00, 0, 8'hC1, 8'hA5, 0, 0));

        // Full 256-byte stream with no end pulse.
        apply("rst_str", mk(1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'hC1, 8'h00, 0, 0));
        for (int i = 0; i < 256; i++)
            apply($sformatf("str_%0d", i),
                  mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'(i) ^ 8'h5A, 0, 8'h00, 8'h00, 1, 1));
        apply("str_ff",  mk(0, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'hA5, 8'h00, 0, 0));
        apply("str_00",  mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h5A, 8'h00, 0, 0));
        apply("str_80",  mk(0, 8'h80, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'hDA, 8'h00, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL expose parameter IMEM_DEPTH, default 256, instruction memory depth in bytes; full 8-bit address space.
REQ-002 SHALL expose parameter DMEM_DEPTH, default 256, data memory depth in bytes; full 8-bit address space.
REQ-003 Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 SaidaPCLeEndereco  in  8  instruction fetch address from the CPU PC.
REQ-006 Instrucao  out  8  instruction byte returned to the CPU.
REQ-007 EnderecoDado  in  8  data memory address from the CPU.
REQ-008 DadoEscrito  in  8  CPU store data.
REQ-009 EscMem  in  1  CPU store strobe.
REQ-010 LerMem  in  1  CPU load strobe.
REQ-011 LeDado  out  8  load data returned to the CPU.
REQ-012 CarregaValido  in  1  loader byte valid.
REQ-013 CarregaDado  in  8  loader program byte.
REQ-014 CarregaFim  in  1  loader end-of-program pulse.
REQ-015 CarregaPronto  out  1  responder accepts loader bytes.
REQ-016 CpuReset  out  1  holds the CPU in reset while the program loads.

Function
REQ-017 The FSM SHALL have two states: LOAD and RUN.
REQ-018 In LOAD: CarregaPronto=1, CpuReset=1, Instrucao=0, LeDado=0, and EscMem/LerMem are ignored.
REQ-019 In LOAD, a cycle with CarregaValido=1 SHALL write CarregaDado to imem[ptr] and increment the 8-bit ptr.
REQ-020 LOAD->RUN SHALL occur on the edge where CarregaFim=1, or where a byte is accepted with ptr=255; ptr then wraps to 0.
REQ-021 If CarregaValido and CarregaFim are both high in one cycle, the byte SHALL be written before entering RUN.
REQ-022 In RUN: CarregaPronto=0, CpuReset=0, and CarregaValido/CarregaDado/CarregaFim are ignored.
REQ-023 RUN SHALL persist until reset; there is no return path to LOAD otherwise.
REQ-024 In RUN, Instrucao SHALL equal imem[SaidaPCLeEndereco] combinationally (zero-latency fetch for the single-cycle CPU).
REQ-025 In RUN, with EscMem=1, dmem[EnderecoDado] SHALL take DadoEscrito at the clock edge.
REQ-026 In RUN, LeDado SHALL equal dmem[EnderecoDado] combinationally when LerMem=1, and 0 otherwise.
REQ-027 With EscMem=LerMem=1 at the same address, LeDado SHALL show the old value in that cycle and the new value in the next cycle.
REQ-028 Imem and dmem SHALL be independent arrays; stores never modify imem.
REQ-029 Unloaded imem locations SHALL hold their prior content; after power-up that content is 0.

Reset
REQ-030 reset=1 at an edge SHALL set state=LOAD and ptr=0, giving CarregaPronto=1, CpuReset=1, Instrucao=0 and LeDado=0 from the next cycle.
REQ-031 reset SHALL NOT clear imem or dmem contents.
REQ-032 reset during LOAD SHALL restart at ptr=0; bytes already written remain until overwritten.
REQ-033 reset SHALL take priority over CarregaValido, CarregaFim and EscMem in the same cycle; no memory write occurs.

Verification
REQ-034 Reset, then load 0x11,0x22,0x33, pulse CarregaFim -> CpuReset=0; PC=1 gives Instrucao=0x22; PC=2 gives 0x33.
REQ-035 Stream 256 bytes with CarregaValido held high, no CarregaFim -> RUN entered after byte 255; PC=0xFF returns the last byte; ptr=0.
REQ-036 In RUN, store 0xA5 to 0x40, then load 0x40 -> LeDado=0xA5; with LerMem=0, LeDado=0.
REQ-037 Same-cycle EscMem+LerMem to 0x10 (old 0x00, new 0x7E) -> LeDado=0x00 in that cycle, 0x7E in the next.
REQ-038 Assert reset after 5 loaded bytes, reload 2 bytes (0xC1,0xC2), then CarregaFim -> imem[0..1]=0xC1,0xC2; imem[2..4] keep the first-load values.
REQ-039 CarregaValido in RUN with 0xFF data -> imem unchanged, CarregaPronto stays 0.
